// File: rtl/neo_pkg.sv
// Shared definitions for the NEO spike detector: FSM encoding, the NEO width
// derivation and the saturating helper used when the threshold is computed.
package neo_pkg;

   typedef enum logic [1:0] {
      ST_PRIME  = 2'd0,
      ST_TRAIN  = 2'd1,
      ST_CALC   = 2'd2,
      ST_DETECT = 2'd3
   } neo_state_e;

   // The difference of two full-precision products needs one extra bit.
   function automatic int neo_width(input int data_w);
      return 2 * data_w + 1;
   endfunction

   // Clamps an unsigned value to the largest positive number of a signed
   // container that is `width` bits wide (width must be 64 or less).
   function automatic logic [63:0] sat_pos_max(input logic [63:0] value, input int width);
      logic [63:0] max_val;
      max_val = (64'd1 << (width - 1)) - 64'd1;
      return (value > max_val) ? max_val : value;
   endfunction

endpackage

// File: rtl/neo_core.sv
// Sample history, two-stage psi pipeline and priming for the NEO detector.
// psi_next/psi_valid are the values neo_out/neo_valid take on the next edge.
module neo_core
   import neo_pkg::*;
#(
   parameter  int DATA_W = 16,
   localparam int NEO_W  = neo_width(DATA_W)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic signed [DATA_W-1:0] data_in,
   output logic signed [NEO_W-1:0]  psi_next,
   output logic                    psi_valid,
   output logic                    neo_valid,
   output logic signed [NEO_W-1:0]  neo_out
);

   logic signed [DATA_W-1:0]   x0;
   logic signed [DATA_W-1:0]   x1;
   logic signed [DATA_W-1:0]   x2;
   logic [1:0]                 prime_cnt;
   logic                       hist_valid;
   logic signed [2*DATA_W-1:0] sq_prod;
   logic signed [2*DATA_W-1:0] cross_prod;
   logic                       prod_valid;

   // The third accepted sample is the first with a complete history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0         <= '0;
         x1         <= '0;
         x2         <= '0;
         prime_cnt  <= '0;
         hist_valid <= 1'b0;
      end else begin
         hist_valid <= in_valid && (prime_cnt >= 2'd2);
         if (in_valid) begin
            x0 <= data_in;
            x1 <= x0;
            x2 <= x1;
            if (prime_cnt != 2'd3) begin
               prime_cnt <= prime_cnt + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sq_prod    <= '0;
         cross_prod <= '0;
         prod_valid <= 1'b0;
      end else begin
         sq_prod    <= x1 * x1;
         cross_prod <= x0 * x2;
         prod_valid <= hist_valid;
      end
   end

   assign psi_next  = $signed({sq_prod[2*DATA_W-1], sq_prod})
                    - $signed({cross_prod[2*DATA_W-1], cross_prod});
   assign psi_valid = prod_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neo_valid <= 1'b0;
         neo_out   <= '0;
      end else begin
         neo_valid <= prod_valid;
         if (prod_valid) begin
            neo_out <= psi_next;
         end
      end
   end

endmodule

// File: rtl/neo_spike_detector.sv
// Streaming NEO spike detector: learns a threshold from the mean clipped NEO
// energy over a training window, then flags spikes with a refractory hold-off.
module neo_spike_detector
   import neo_pkg::*;
#(
   parameter  int DATA_W      = 16,
   parameter  int TRAIN_LOG2  = 10,
   parameter  int THR_MULT    = 8,
   parameter  int THR_INIT    = 20000,
   parameter  int REFRACT_LEN = 32,
   localparam int NEO_W       = neo_width(DATA_W)
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic                    retrain,
   output logic                    neo_valid,
   output logic signed [NEO_W-1:0]  neo_out,
   output logic                    spike,
   output logic signed [NEO_W-1:0]  threshold,
   output logic                    trained,
   output logic [1:0]              state
);

   localparam int ACC_W = NEO_W + TRAIN_LOG2;
   localparam int RF_W  = (REFRACT_LEN > 0) ? $clog2(REFRACT_LEN + 1) : 1;

   logic signed [NEO_W-1:0] psi_next;
   logic                    psi_valid;
   logic [NEO_W-1:0]        psi_pos;
   logic [NEO_W-1:0]        mean;
   logic [63:0]             scaled;
   logic [63:0]             thr_sat;
   logic                    retrain_take;

   neo_state_e              cur_state;
   logic [ACC_W-1:0]        acc;
   logic [TRAIN_LOG2-1:0]   train_cnt;
   logic [RF_W-1:0]         refract_cnt;

   neo_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .psi_next  (psi_next),
      .psi_valid (psi_valid),
      .neo_valid (neo_valid),
      .neo_out   (neo_out)
   );

   assign psi_pos      = psi_next[NEO_W-1] ? '0 : psi_next;
   assign mean         = NEO_W'(acc >> TRAIN_LOG2);
   assign scaled       = 64'(mean) * 64'(THR_MULT);
   assign thr_sat      = sat_pos_max(scaled, NEO_W);
   assign retrain_take = retrain && (cur_state != ST_PRIME);
   assign state        = cur_state;

   // The FSM acts on the psi about to be registered, so spike lines up with
   // the neo_valid of the sample that triggered it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state   <= ST_PRIME;
         acc         <= '0;
         train_cnt   <= '0;
         refract_cnt <= '0;
         threshold   <= NEO_W'(THR_INIT);
         trained     <= 1'b0;
         spike       <= 1'b0;
      end else begin
         spike <= 1'b0;
         if (retrain_take) begin
            cur_state   <= ST_TRAIN;
            acc         <= '0;
            train_cnt   <= '0;
            refract_cnt <= '0;
         end else begin
            case (cur_state)
               ST_PRIME: begin
                  if (psi_valid) begin
                     cur_state <= ST_TRAIN;
                     acc       <= ACC_W'(psi_pos);
                     train_cnt <= TRAIN_LOG2'(1);
                  end
               end
               ST_TRAIN: begin
                  if (psi_valid) begin
                     acc       <= acc + ACC_W'(psi_pos);
                     train_cnt <= train_cnt + TRAIN_LOG2'(1);
                     if (&train_cnt) begin
                        cur_state <= ST_CALC;
                     end
                  end
               end
               ST_CALC: begin
                  threshold <= NEO_W'(thr_sat);
                  trained   <= 1'b1;
                  acc       <= '0;
                  train_cnt <= '0;
                  cur_state <= ST_DETECT;
               end
               ST_DETECT: begin
                  if (psi_valid) begin
                     if (refract_cnt != '0) begin
                        refract_cnt <= refract_cnt - RF_W'(1);
                     end else if (psi_next > threshold) begin
                        spike <= 1'b1;
                        if (REFRACT_LEN > 0) begin
                           refract_cnt <= RF_W'(REFRACT_LEN);
                        end
                     end
                  end
               end
               default: cur_state <= ST_PRIME;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_neo_spike_detector.sv
// Directed bench for neo_spike_detector (TRAIN_LOG2=4, THR_MULT=8, REFRACT_LEN=4)
// with hand-computed expectations checked by immediate assertions.
module tb_neo_spike_detector;

   localparam int DATA_W = 16;
   localparam int NEO_W  = 2 * DATA_W + 1;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     in_valid;
   logic signed [DATA_W-1:0] data_in;
   logic                     retrain;
   logic                     neo_valid;
   logic signed [NEO_W-1:0]  neo_out;
   logic                     spike;
   logic signed [NEO_W-1:0]  threshold;
   logic                     trained;
   logic [1:0]               state;

   int assert_cnt = 0;
   int fail_cnt   = 0;
   int spike_cnt  = 0;
   int nv_cnt     = 0;
   logic signed [NEO_W-1:0] last_spike_psi = '0;

   always #5 clk = ~clk;

   neo_spike_detector #(
      .DATA_W      (DATA_W),
      .TRAIN_LOG2  (4),
      .THR_MULT    (8),
      .THR_INIT    (20000),
      .REFRACT_LEN (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .retrain   (retrain),
      .neo_valid (neo_valid),
      .neo_out   (neo_out),
      .spike     (spike),
      .threshold (threshold),
      .trained   (trained),
      .state     (state)
   );

   // Tallies output pulses shortly after each rising edge.
   always @(posedge clk) begin
      #1;
      if (neo_valid === 1'b1) nv_cnt++;
      if (spike === 1'b1) begin
         spike_cnt++;
         last_spike_psi = neo_out;
      end
   end

   task automatic applyStimulus(input logic v, input logic signed [DATA_W-1:0] d, input logic rt);
      @(negedge clk);
      in_valid = v;
      data_in  = d;
      retrain  = rt;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
   endtask

   task automatic sendSeq(input int seq[$]);
      foreach (seq[i]) applyStimulus(1'b1, DATA_W'(seq[i]), 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      assert_cnt++;
      assert (observed === expected) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int seq[$];
      int accepted;
      logic v;

      in_valid = 1'b0;
      data_in  = '0;
      retrain  = 1'b0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_neo_valid", neo_valid, 0);
      checkOutput("rst_neo_out",   neo_out,   0);
      checkOutput("rst_spike",     spike,     0);
      checkOutput("rst_threshold", threshold, 20000);
      checkOutput("rst_trained",   trained,   0);
      checkOutput("rst_state",     state,     0);
      rst_n = 1'b1;

      // Training on 0,10,...: psi alternates +100/-100, threshold 8*50 = 400
      $display("[TB] training on alternating 0/10");
      nv_cnt = 0;
      spike_cnt = 0;
      for (int i = 0; i < 18; i++) applyStimulus(1'b1, (i % 2 == 1) ? 16'sd10 : 16'sd0, 1'b0);
      idle(3);
      checkOutput("calc_neo_valid", neo_valid, 1);
      checkOutput("calc_neo_out",   neo_out,   -100);
      checkOutput("calc_state",     state,     2);
      checkOutput("calc_trained",   trained,   0);
      checkOutput("calc_threshold", threshold, 20000);
      idle(1);
      checkOutput("det_state",      state,     3);
      checkOutput("det_trained",    trained,   1);
      checkOutput("det_threshold",  threshold, 400);
      checkOutput("train_nv_count", nv_cnt,    16);
      checkOutput("train_spikes",   spike_cnt, 0);

      // Impulse: psi = 1e6 one sample after the 1000
      $display("[TB] impulse detection");
      spike_cnt = 0;
      seq = '{0, 0, 1000, 0};
      sendSeq(seq);
      applyStimulus(1'b1, 16'sd0, 1'b0);
      idle(1);
      checkOutput("imp_spike_early", spike, 0);
      idle(1);
      checkOutput("imp_spike",       spike,     1);
      checkOutput("imp_neo_valid",   neo_valid, 1);
      checkOutput("imp_neo_out",     neo_out,   1000000);
      idle(1);
      checkOutput("imp_spike_single", spike, 0);
      seq = '{0, 0, 0, 0, 0, 0, 0, 0};
      sendSeq(seq);
      idle(3);
      checkOutput("imp_spike_count", spike_cnt, 1);

      // Threshold boundary: psi = 400 stays quiet, psi = 401 fires
      spike_cnt = 0;
      seq = '{20, 0, 0, 0, 0, 0};
      sendSeq(seq);
      idle(3);
      checkOutput("eq_thr_no_spike", spike_cnt, 0);
      seq = '{1, 20, -1, 0, 0, 0, 0, 0, 0};
      sendSeq(seq);
      idle(3);
      checkOutput("above_thr_spike", spike_cnt, 1);
      checkOutput("above_thr_psi",   last_spike_psi, 401);

      // Refractory of 4: impulses 3 apart give one spike, 6 apart give two
      $display("[TB] refractory spacing");
      spike_cnt = 0;
      seq = '{1000, 0, 0, 1000, 0, 0, 0, 0, 0, 0};
      sendSeq(seq);
      idle(3);
      checkOutput("refr_3_apart", spike_cnt, 1);
      spike_cnt = 0;
      seq = '{1000, 0, 0, 0, 0, 0, 1000, 0, 0, 0, 0, 0, 0, 0};
      sendSeq(seq);
      idle(3);
      checkOutput("refr_6_apart", spike_cnt, 2);

      // Retrain while refractory is active; new data 30,0,...: threshold 8*450
      $display("[TB] retrain mid-refractory");
      spike_cnt = 0;
      seq = '{1000, 0, 0};
      sendSeq(seq);
      idle(3);
      checkOutput("rt_pre_spike", spike_cnt, 1);
      applyStimulus(1'b0, '0, 1'b1);
      idle(1);
      checkOutput("rt_state",     state,     1);
      checkOutput("rt_threshold", threshold, 400);
      checkOutput("rt_trained",   trained,   1);
      nv_cnt = 0;
      spike_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, (i % 2 == 0) ? 16'sd30 : 16'sd0, 1'b0);
         if (i == 8) begin
            checkOutput("rt_mid_threshold", threshold, 400);
            checkOutput("rt_mid_state",     state,     1);
         end
      end
      idle(4);
      checkOutput("rt_new_state",     state,     3);
      checkOutput("rt_new_threshold", threshold, 3600);
      checkOutput("rt_no_spikes",     spike_cnt, 0);
      checkOutput("rt_nv_count",      nv_cnt,    16);

      // Async reset mid-training with gapped input
      $display("[TB] async reset and gapped valid");
      applyStimulus(1'b0, '0, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'($urandom_range(0, 1)), 16'sd50, 1'b0);
      checkOutput("ar_pre_state", state, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("ar_state",     state,     0);
      checkOutput("ar_threshold", threshold, 20000);
      checkOutput("ar_trained",   trained,   0);
      checkOutput("ar_neo_valid", neo_valid, 0);
      checkOutput("ar_neo_out",   neo_out,   0);
      checkOutput("ar_spike",     spike,     0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      nv_cnt = 0;
      accepted = 0;
      for (int k = 0; k < 60 && accepted < 2; k++) begin
         v = (k >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
         applyStimulus(v, (accepted == 0) ? 16'sd2 : 16'sd3, 1'b0);
         if (v) accepted++;
      end
      idle(4);
      checkOutput("prime_no_valid", nv_cnt, 0);
      checkOutput("prime_state",    state,  0);
      applyStimulus(1'b1, 16'sd5, 1'b0);
      idle(4);
      checkOutput("prime_first_valid", nv_cnt,  1);
      checkOutput("prime_first_psi",   neo_out, -1);
      checkOutput("prime_to_train",    state,   1);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
